cfg_axil_initiator: RTL
=======================

// Module: cfg_axil_initiator
// PURPOSE
//  AXI4-Lite initiator driving the cfg_* register bus of peripherals such as gpio. Converts one
//  simple command (read or write, addr, data, strobes) into a single AXI4-Lite transaction and
//  returns read data and status. One transaction outstanding at a time; per-transaction timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles from AW/W or AR issue to B/R handshake before abort; 0 disables
//  TO_W            16    width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk_i             in   1   clock
//  rst_i             in   1   reset, asynchronous, active-high
//  cmd_valid_i       in   1   command request
//  cmd_ready_o       out  1   command accepted when cmd_valid_i & cmd_ready_o
//  cmd_write_i       in   1   1 = write, 0 = read
//  cmd_addr_i        in   32  byte address
//  cmd_wdata_i       in   32  write data
//  cmd_wstrb_i       in   4   write byte strobes
//  rsp_valid_o       out  1   response available
//  rsp_ready_i       in   1   response consumed when rsp_valid_o & rsp_ready_i
//  rsp_rdata_o       out  32  read data (0 for writes and on timeout)
//  rsp_err_o         out  1   B/R resp != OKAY
//  rsp_timeout_o     out  1   transaction aborted by timeout
//  cfg_awvalid_o/cfg_awaddr_o[32]/cfg_wvalid_o/cfg_wdata_o[32]/cfg_wstrb_o[4]  out  write request
//  cfg_awready_i/cfg_wready_i  in  1  write accept
//  cfg_bvalid_i  in 1, cfg_bresp_i  in 2, cfg_bready_o  out 1   write response
//  cfg_arvalid_o out 1, cfg_araddr_o out 32, cfg_arready_i in 1  read request
//  cfg_rvalid_i in 1, cfg_rdata_i in 32, cfg_rresp_i in 2, cfg_rready_o out 1  read response
// BEHAVIOUR
//  Reset: state IDLE; all valids 0, cmd_ready_o 1, rsp_* 0, addr/data outputs 0, counter 0.
//  FSM: IDLE -> WR (cmd write) | RD (cmd read); WR -> WRESP when both AW and W handshaken;
//   WRESP -> RSP on bvalid; RD -> RDATA on AR handshake; RDATA -> RSP on rvalid; RSP -> IDLE on
//   rsp handshake. cmd_ready_o = (state==IDLE). All bus outputs registered.
//  Command accepted in cycle N: AW+W (or AR) valid from N+1. AW and W always presented together;
//   each tracked by its own done flag, valid of each drops the cycle after its own handshake.
//   Address, data, strobe held stable while valid is high (AXI rule; never retracted early).
//  cfg_bready_o = 1 in WRESP and IDLE; cfg_rready_o = 1 in RDATA and IDLE. B/R arriving in IDLE
//   are late responses of a timed-out transaction: consumed and discarded, no rsp generated.
//  Response registered: rsp_valid_o rises cycle after B/R handshake; rdata/err captured there;
//   held stable until rsp_ready_i. rsp_err_o = (resp != 2'b00).
//  Zero-wait slave (gpio): write accepted N, AW/W hs N+1, B N+2, rsp_valid_o N+3; read same.
//  Timeout: counter clears on entry to WR/RD, increments each cycle in WR/WRESP/RD/RDATA;
//   at count == TIMEOUT_CYCLES-1 with no completing handshake: rsp_timeout_o=1, rsp_err_o=1,
//   rdata 0, go to RSP. If valids still high at abort they drop (documented debug deviation).
//   Handshake in the expiry cycle wins over timeout.
//  Simultaneous: AW hs and W hs in same cycle -> WRESP next cycle. rsp_ready_i high on same cycle
//   rsp_valid_o rises -> IDLE next cycle; cmd accept earliest the cycle after.
//  Reset mid-transaction: outputs return to reset values immediately (async); in-flight command
//   and response lost; slave-side recovery is the slave's reset.
// STRUCTURE
//  Shared package cfg_bus_pkg: AXI resp codes (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11), FSM state
//   encoding, cfg register offsets reused by benches.
//  One sub-module: cfg_timeout_ctr (clear, enable, expire at TIMEOUT_CYCLES, disabled when 0).
// TESTING (bench: initiator connected to gpio)
//  Write 0x0000_00FF to 0x00 (direction) -> rsp_valid N+3, err 0; gpio_output_enable_o=0xFF.
//  Read 0x00 after above -> rsp_rdata_o=0x0000_00FF, err 0, rsp_valid N+3.
//  Slave model awready delayed 5 cycles, wready 0-cycle -> W valid drops first, AW held stable,
//   single B, one rsp.
//  TIMEOUT_CYCLES=8, slave never returns bvalid -> rsp_timeout_o=1 on cycle 8 after issue; late
//   bvalid 3 cycles into IDLE drained, no extra rsp.
//  Slave returns rresp=2'b10 with rdata 0xDEAD_BEEF -> rsp_err_o=1, rdata 0xDEAD_BEEF.
//  rst_i pulsed while in WRESP -> all outputs reset values same cycle; next command completes.

Source files
------------

// File: rtl/cfg_bus_pkg.sv
// Shared definitions for the cfg_* AXI4-Lite register bus: response codes,
// initiator FSM encoding, request/response records and peripheral offsets.
package cfg_bus_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // gpio register map, byte offsets
  localparam logic [31:0] GPIO_DIR_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_OUT_OFS = 32'h0000_0004;
  localparam logic [31:0] GPIO_IN_OFS  = 32'h0000_0008;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WRESP = 3'd2,
    ST_RD    = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } cfg_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cfg_cmd_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } cfg_rsp_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/cfg_timeout_ctr.sv
// Per-transaction watchdog: cleared at command accept, counts while a bus phase
// is pending and holds expired once TIMEOUT_CYCLES-1 is reached (0 disables).
module cfg_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam bit            ENABLE = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] LIMIT = ENABLE ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TO_W-1:0] cnt_q;

  // Saturating: a handshake landing in the expiry cycle moves the FSM on, and
  // the next phase must still see the expired budget.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                      cnt_q <= '0;
    else if (clr_i)                 cnt_q <= '0;
    else if (en_i && cnt_q != LIMIT) cnt_q <= cnt_q + 1'b1;
  end

  assign expired_o = ENABLE && (cnt_q == LIMIT);

endmodule

// File: rtl/cfg_axil_initiator.sv
// AXI4-Lite initiator: one command in, one single-beat cfg_* transaction out,
// one registered response back. Single outstanding transaction with timeout.
module cfg_axil_initiator
  import cfg_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        cfg_awvalid_o,
  output logic [31:0] cfg_awaddr_o,
  input  logic        cfg_awready_i,
  output logic        cfg_wvalid_o,
  output logic [31:0] cfg_wdata_o,
  output logic [3:0]  cfg_wstrb_o,
  input  logic        cfg_wready_i,
  input  logic        cfg_bvalid_i,
  input  logic [1:0]  cfg_bresp_i,
  output logic        cfg_bready_o,
  output logic        cfg_arvalid_o,
  output logic [31:0] cfg_araddr_o,
  input  logic        cfg_arready_i,
  input  logic        cfg_rvalid_i,
  input  logic [31:0] cfg_rdata_i,
  input  logic [1:0]  cfg_rresp_i,
  output logic        cfg_rready_o
);

  cfg_state_e state_q, state_d;
  cfg_cmd_t   cmd_q, cmd_d;
  cfg_rsp_t   rsp_q, rsp_d;
  logic       awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       bready_q, bready_d, rready_q, rready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic       cmd_fire, ctr_en, expired, abort;

  assign aw_hs    = awvalid_q && cfg_awready_i;
  assign w_hs     = wvalid_q  && cfg_wready_i;
  assign ar_hs    = arvalid_q && cfg_arready_i;
  assign b_hs     = bready_q  && cfg_bvalid_i;
  assign r_hs     = rready_q  && cfg_rvalid_i;
  assign cmd_fire = cmd_valid_i && (state_q == ST_IDLE);
  assign ctr_en   = (state_q == ST_WR) || (state_q == ST_WRESP) ||
                    (state_q == ST_RD) || (state_q == ST_RDATA);

  cfg_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (cmd_fire),
    .en_i     (ctr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    awvalid_d   = awvalid_q && !aw_hs;
    wvalid_d    = wvalid_q  && !w_hs;
    arvalid_d   = arvalid_q && !ar_hs;
    aw_done_d   = aw_done_q || aw_hs;
    w_done_d    = w_done_q  || w_hs;
    abort       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d.addr = cmd_addr_i;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          if (cmd_write_i) begin
            state_d     = ST_WR;
            cmd_d.wdata = cmd_wdata_i;
            cmd_d.wstrb = cmd_wstrb_i;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
          end else begin
            state_d   = ST_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (aw_done_d && w_done_d) state_d = ST_WRESP;
        else if (expired)          abort   = 1'b1;
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_d       = '{rdata: '0, err: resp_is_err(cfg_bresp_i), timeout: 1'b0};
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RD: begin
        if (ar_hs)        state_d = ST_RDATA;
        else if (expired) abort   = 1'b1;
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_d     = ST_RSP;
          rsp_valid_d = 1'b1;
          rsp_d       = '{rdata: cfg_rdata_i, err: resp_is_err(cfg_rresp_i), timeout: 1'b0};
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          rsp_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort withdraws any still-pending request; a late B/R is drained in IDLE.
    if (abort) begin
      state_d     = ST_RSP;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      arvalid_d   = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_d       = '{rdata: '0, err: 1'b1, timeout: 1'b1};
    end

    bready_d = (state_d == ST_IDLE) || (state_d == ST_WRESP);
    rready_d = (state_d == ST_IDLE) || (state_d == ST_RDATA);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b1;
      rready_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
    end
  end

  assign cmd_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_q.rdata;
  assign rsp_err_o     = rsp_q.err;
  assign rsp_timeout_o = rsp_q.timeout;
  assign cfg_awvalid_o = awvalid_q;
  assign cfg_awaddr_o  = cmd_q.addr;
  assign cfg_wvalid_o  = wvalid_q;
  assign cfg_wdata_o   = cmd_q.wdata;
  assign cfg_wstrb_o   = cmd_q.wstrb;
  assign cfg_bready_o  = bready_q;
  assign cfg_arvalid_o = arvalid_q;
  assign cfg_araddr_o  = cmd_q.addr;
  assign cfg_rready_o  = rready_q;

endmodule
